bin_to_bcd_converter: RTL

Sequential binary-to-packed-BCD converter using the shift-and-add-3 (double dabble) method. It sits directly upstream of the two-digit seven-segment decoder. Its `bcd` output drives the decoder's 8-bit address: upper nibble is the tens digit, lower nibble is the units digit. This lets a binary count (0..99) show as decimal on the two-digit display. Out-of-range inputs saturate to 99 and raise a flag.

---
 rtl/bin_to_bcd_converter_pkg.sv | 14 +
 rtl/bin_to_bcd_converter_if.sv | 18 +
 rtl/bcd_digit_adjust.sv | 9 +
 rtl/bin_to_bcd_converter.sv | 94 +++++++++
 4 files changed

// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
package bin_to_bcd_converter_pkg;

  localparam int ND      = 2;
  localparam int BCD_MAX = 99;
  localparam logic [4*ND-1:0] BCD_SAT = 8'h99;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bin_to_bcd_converter_if.sv
// Request/result bundle between a requester and the BCD converter.
interface bin_to_bcd_converter_if
  import bin_to_bcd_converter_pkg::*;
#(
  parameter int BW = 8
);

  logic              start;
  logic [BW-1:0]     bin;
  logic              busy;
  logic              done;
  logic [4*ND-1:0]   bcd;
  logic              ovf;

  modport master (output start, output bin, input busy, input done, input bcd, input ovf);
  modport slave  (input start, input bin, output busy, output done, output bcd, output ovf);

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD nibble of 5 or more.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-and-add-3 binary to packed two-digit BCD converter.
// Inputs above 99 saturate to 0x99 and raise ovf.
//
// state   | meaning
// S_IDLE  | waiting for start, outputs held
// S_SHIFT | BW adjust-and-shift steps on the scratch register
// S_DONE  | publish bcd/ovf, pulse done
module bin_to_bcd_converter
  import bin_to_bcd_converter_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  bin_to_bcd_converter_if.slave    bif
);

  localparam int SW    = 4*ND + BW;
  localparam int CNT_W = $clog2(BW + 1);
  localparam logic [BW-1:0] BIN_MAX = BW'(BCD_MAX);

  state_e            state_q;
  logic [SW-1:0]     scratch_q;
  logic [SW-1:0]     adj;
  logic [SW-1:0]     scratch_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_nx_q;
  logic              busy_q;
  logic              done_q;
  logic [4*ND-1:0]   bcd_q;
  logic              ovf_q;

  // Only the BCD nibbles above the binary field get corrected.
  assign adj[BW-1:0] = scratch_q[BW-1:0];

  for (genvar g = 0; g < ND; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (scratch_q[BW+4*g +: 4]),
      .digit_o (adj[BW+4*g +: 4])
    );
  end

  assign scratch_d = adj << 1;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_nx_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bif.start) begin
            scratch_q <= {{(4*ND){1'b0}}, bif.bin};
            cnt_q     <= CNT_W'(BW);
            ovf_nx_q  <= (bif.bin > BIN_MAX);
            busy_q    <= 1'b1;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_q   <= ovf_nx_q ? BCD_SAT : scratch_q[SW-1:BW];
          ovf_q   <= ovf_nx_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bif.busy = busy_q;
  assign bif.done = done_q;
  assign bif.bcd  = bcd_q;
  assign bif.ovf  = ovf_q;

endmodule
